// File: rtl/tt_sel_seq_pkg.sv
// tt_sel_seq shared types and defaults.
// State encoding, timer width and default phase lengths.
package tt_sel_seq_pkg;

  localparam int TMR_W          = 8;
  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_N_ADDR     = 1024;
  localparam int DEF_RST_CYC    = 4;
  localparam int DEF_PULSE_CYC  = 2;
  localparam int DEF_SETTLE_CYC = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RST    = 3'd1,
    ST_INC_HI = 3'd2,
    ST_INC_LO = 3'd3,
    ST_SETTLE = 3'd4,
    ST_DONE   = 3'd5
  } sel_st_e;

endpackage

// File: rtl/tt_sel_seq_if.sv
// Request/response bundle between host and selection sequencer.
// master = requester, slave = sequencer.
interface tt_sel_seq_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ena;
  logic              req_ready;
  logic              done;
  logic              err;

  modport master (
    output req_valid, req_addr, req_ena,
    input  req_ready, done, err
  );

  modport slave (
    input  req_valid, req_addr, req_ena,
    output req_ready, done, err
  );
endinterface

// File: rtl/tt_sel_timer.sv
// Loadable down-counter shared by the reset, pulse and settle phases.
// Stops at zero; a load of N-1 gives an N-cycle phase.
module tt_sel_timer
  import tt_sel_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             zero
);

  logic [TMR_W-1:0] val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val <= '0;
    end else if (load) begin
      val <= load_val;
    end else if (val != '0) begin
      val <= val - 1'b1;
    end
  end

  assign zero = (val == '0);

endmodule

// File: rtl/tt_sel_seq.sv
// Tiny Tapeout mux selection sequencer: reset, N inc pulses, settle, enable.
// Outputs are registered from the next state so they align with it.
module tt_sel_seq
  import tt_sel_seq_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int N_ADDR     = DEF_N_ADDR,
  parameter int RST_CYC    = DEF_RST_CYC,
  parameter int PULSE_CYC  = DEF_PULSE_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  tt_sel_seq_if.slave       bus,
  output logic              sel_rst_n,
  output logic              sel_inc,
  output logic              ena,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              cur_valid
);

  localparam logic [TMR_W-1:0] RST_LD =
    TMR_W'(RST_CYC - 1);
  localparam logic [TMR_W-1:0] PULSE_LD =
    TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] SETTLE_LD =
    TMR_W'((SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1);

  sel_st_e state, state_n;

  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [ADDR_W-1:0] tgt_addr;
  logic              tgt_ena;
  logic [ADDR_W-1:0] fin_addr;
  logic              fin_ena;
  logic              oor;
  logic              range_err;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_ld_val;
  logic              tmr_zero;

  tt_sel_timer u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_ld_val),
    .zero     (tmr_zero)
  );

  assign oor = {1'b0, bus.req_addr} >= (ADDR_W+1)'(N_ADDR);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    tmr_load   = 1'b0;
    tmr_ld_val = '0;
    range_err  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (oor) begin
            range_err = 1'b1;
          end else if (cur_valid &&
                       bus.req_addr == cur_addr) begin
            state_n = ST_DONE;
          end else begin
            state_n    = ST_RST;
            tmr_load   = 1'b1;
            tmr_ld_val = RST_LD;
            cnt_n      = bus.req_addr;
          end
        end
      end
      ST_RST: begin
        if (tmr_zero) begin
          if (cnt == '0) begin
            if (SETTLE_CYC == 0) begin
              state_n = ST_DONE;
            end else begin
              state_n    = ST_SETTLE;
              tmr_load   = 1'b1;
              tmr_ld_val = SETTLE_LD;
            end
          end else begin
            state_n    = ST_INC_HI;
            tmr_load   = 1'b1;
            tmr_ld_val = PULSE_LD;
          end
        end
      end
      ST_INC_HI: begin
        if (tmr_zero) begin
          state_n    = ST_INC_LO;
          tmr_load   = 1'b1;
          tmr_ld_val = PULSE_LD;
        end
      end
      ST_INC_LO: begin
        if (tmr_zero) begin
          if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
          end
          if (cnt <= ADDR_W'(1)) begin
            if (SETTLE_CYC == 0) begin
              state_n = ST_DONE;
            end else begin
              state_n    = ST_SETTLE;
              tmr_load   = 1'b1;
              tmr_ld_val = SETTLE_LD;
            end
          end else begin
            state_n    = ST_INC_HI;
            tmr_load   = 1'b1;
            tmr_ld_val = PULSE_LD;
          end
        end
      end
      ST_SETTLE: begin
        if (tmr_zero) begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Fast path reaches DONE straight from IDLE, before the capture lands.
  always_comb begin
    fin_ena  = tgt_ena;
    fin_addr = tgt_addr;
    if (state == ST_IDLE) begin
      fin_ena  = bus.req_ena;
      fin_addr = bus.req_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      tgt_addr <= '0;
      tgt_ena  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == ST_IDLE && bus.req_valid && !oor) begin
        tgt_addr <= bus.req_addr;
        tgt_ena  <= bus.req_ena;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.req_ready <= 1'b1;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      sel_rst_n     <= 1'b0;
      sel_inc       <= 1'b0;
      ena           <= 1'b0;
      cur_addr      <= '0;
      cur_valid     <= 1'b0;
    end else begin
      bus.req_ready <= (state_n == ST_IDLE);
      bus.done      <= (state_n == ST_DONE);
      bus.err       <= range_err;
      sel_inc       <= (state_n == ST_INC_HI);
      if (state_n == ST_RST) begin
        sel_rst_n <= 1'b0;
        ena       <= 1'b0;
        cur_valid <= 1'b0;
      end else if (state == ST_RST) begin
        sel_rst_n <= 1'b1;
      end
      if (state_n == ST_DONE) begin
        ena       <= fin_ena;
        cur_addr  <= fin_addr;
        cur_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tt_sel_seq.sv
// Directed bench for tt_sel_seq.
// Second instance with an 11-bit address exercises the range check.
module tb_tt_sel_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  tt_sel_seq_if #(.ADDR_W(10)) bus ();
  tt_sel_seq_if #(.ADDR_W(11)) bus2 ();

  logic       sel_rst_n, sel_inc, ena, cur_valid;
  logic [9:0] cur_addr;
  logic       sel_rst_n2, sel_inc2, ena2, cur_valid2;
  logic [10:0] cur_addr2;

  tt_sel_seq u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .sel_rst_n (sel_rst_n),
    .sel_inc   (sel_inc),
    .ena       (ena),
    .cur_addr  (cur_addr),
    .cur_valid (cur_valid)
  );

  tt_sel_seq #(.ADDR_W(11), .N_ADDR(1024)) u_oor (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus2.slave),
    .sel_rst_n (sel_rst_n2),
    .sel_inc   (sel_inc2),
    .ena       (ena2),
    .cur_addr  (cur_addr2),
    .cur_valid (cur_valid2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Waveform monitor, armed from the cycle after acceptance
  logic mon_on = 1'b0;
  logic inc_prev;
  int   n_rise, n_hi, n_rstlo, n_bad, rst_first;

  always @(negedge clk) begin
    if (!mon_on) begin
      n_rise    <= 0;
      n_hi      <= 0;
      n_rstlo   <= 0;
      n_bad     <= 0;
      rst_first <= -1;
      inc_prev  <= 1'b0;
    end else begin
      inc_prev <= sel_inc;
      if (sel_inc && !inc_prev) n_rise <= n_rise + 1;
      if (sel_inc) n_hi <= n_hi + 1;
      if (!sel_rst_n) n_rstlo <= n_rstlo + 1;
      if (!sel_rst_n && rst_first < 0) rst_first <= cyc;
      if (sel_inc && !sel_rst_n) n_bad <= n_bad + 1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic accept(input logic [9:0] a, input logic e,
                        output int k);
    mon_on = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_ena   = e;
    @(posedge clk);
    #1;
    k = cyc;
    bus.req_valid = 1'b0;
    mon_on = 1'b1;
  endtask

  task automatic wait_done(input int k, output int lat);
    lat = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = cyc - k + 1;
        break;
      end
    end
  endtask

  int k, lat, r;
  logic p;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_ena    = 1'b0;
    bus2.req_valid = 1'b0;
    bus2.req_addr  = '0;
    bus2.req_ena   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_sel_rst_n", int'(sel_rst_n), 0);
    check("rst_sel_inc", int'(sel_inc), 0);
    check("rst_ena", int'(ena), 0);
    check("rst_ready", int'(bus.req_ready), 1);
    check("rst_cur_valid", int'(cur_valid), 0);
    check("rst_done", int'(bus.done), 0);
    @(posedge clk);
    #1;

    // Full sequence, addr 3
    accept(10'd3, 1'b1, k);
    wait_done(k, lat);
    check("full_lat", lat, 20);
    check("full_ena", int'(ena), 1);
    check("full_cur_addr", int'(cur_addr), 3);
    check("full_cur_valid", int'(cur_valid), 1);
    check("full_rises", n_rise, 3);
    check("full_hi_cyc", n_hi, 6);
    check("full_rst_lo", n_rstlo, 4);
    check("full_rst_start", rst_first - k + 1, 1);
    check("full_glitch", n_bad, 0);
    check("full_ready_done", int'(bus.req_ready), 0);
    @(negedge clk);
    check("full_ready_after", int'(bus.req_ready), 1);
    check("full_done_pulse", int'(bus.done), 0);
    @(posedge clk);
    #1;

    // Fast path: same address, enable off
    accept(10'd3, 1'b0, k);
    wait_done(k, lat);
    check("fast_lat", lat, 1);
    check("fast_ena", int'(ena), 0);
    check("fast_sel_rst_n", int'(sel_rst_n), 1);
    check("fast_rises", n_rise, 0);
    check("fast_rst_lo", n_rstlo, 0);
    check("fast_cur_addr", int'(cur_addr), 3);
    @(posedge clk);
    #1;

    // Zero address
    accept(10'd0, 1'b1, k);
    wait_done(k, lat);
    check("zero_lat", lat, 8);
    check("zero_rises", n_rise, 0);
    check("zero_rst_lo", n_rstlo, 4);
    check("zero_ena", int'(ena), 1);
    check("zero_cur_addr", int'(cur_addr), 0);
    @(posedge clk);
    #1;

    // Out of range on the wide instance
    bus2.req_valid = 1'b1;
    bus2.req_addr  = 11'd1024;
    bus2.req_ena   = 1'b1;
    @(posedge clk);
    #1 bus2.req_valid = 1'b0;
    @(negedge clk);
    check("oor_err", int'(bus2.err), 1);
    check("oor_ready", int'(bus2.req_ready), 1);
    check("oor_sel_rst_n", int'(sel_rst_n2), 0);
    check("oor_ena", int'(ena2), 0);
    check("oor_cur_valid", int'(cur_valid2), 0);
    check("oor_done", int'(bus2.done), 0);
    @(negedge clk);
    check("oor_err_pulse", int'(bus2.err), 0);
    @(posedge clk);
    #1;
    bus2.req_valid = 1'b1;
    bus2.req_addr  = 11'd1023;
    @(posedge clk);
    #1 bus2.req_valid = 1'b0;
    @(negedge clk);
    check("inrange_err", int'(bus2.err), 0);
    check("inrange_ready", int'(bus2.req_ready), 0);
    @(posedge clk);
    #1;

    // Reset during the second INC_HI of addr 5
    accept(10'd5, 1'b1, k);
    r = 0;
    p = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sel_inc && !p) r++;
      p = sel_inc;
      if (r == 2) break;
    end
    check("mid_rise_seen", r, 2);
    rst_n = 1'b0;
    #1;
    check("mid_sel_rst_n", int'(sel_rst_n), 0);
    check("mid_sel_inc", int'(sel_inc), 0);
    check("mid_ena", int'(ena), 0);
    check("mid_ready", int'(bus.req_ready), 1);
    check("mid_cur_valid", int'(cur_valid), 0);
    check("mid_cur_addr", int'(cur_addr), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    accept(10'd2, 1'b1, k);
    wait_done(k, lat);
    check("after_lat", lat, 16);
    check("after_rises", n_rise, 2);
    check("after_hi_cyc", n_hi, 4);
    check("after_ena", int'(ena), 1);
    check("after_cur_addr", int'(cur_addr), 2);
    check("after_glitch", n_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
